// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, sync polarity and the registered control-bundle type.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int   CNT_W       = 10;
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic line_start;
    logic frame_start;
  } vga_ctl_t;

  localparam vga_ctl_t CTL_RST = '{
    hs:          ~SYNC_ACTIVE,
    vs:          ~SYNC_ACTIVE,
    blank:       1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/visible decode of the *next* count,
// so the parent can register the decode and have it line up with the counter flop.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FP      = H_FP_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BP      = H_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sync_nxt_o,
  output logic             vis_nxt_o
);

  localparam int TOTAL = VISIBLE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = step_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (step_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
    sync_nxt_o = ((cnt_d >= SYNC_LO) && (cnt_d <= SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vis_nxt_o  = (cnt_d < VIS_END);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator; hs/vs/blank/line_start/frame_start are registered and aligned with DrawX/DrawY.
// Define VGA_TIMING_PIPE_EN to delay those five by one extra vga_clk to match a synchronous sprite ROM.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic             vga_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             hs,
  output logic             vs,
  output logic             blank,
  output logic             sync,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  logic     h_wrap, h_sync_nxt, h_vis_nxt;
  logic     v_wrap, v_sync_nxt, v_vis_nxt;
  vga_ctl_t ctl_d, ctl_q, ctl_out;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_axis (
    .clk_i      (vga_clk),
    .rst_i      (reset),
    .step_i     (1'b1),
    .cnt_o      (DrawX),
    .wrap_o     (h_wrap),
    .sync_nxt_o (h_sync_nxt),
    .vis_nxt_o  (h_vis_nxt)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_axis (
    .clk_i      (vga_clk),
    .rst_i      (reset),
    .step_i     (h_wrap),
    .cnt_o      (DrawY),
    .wrap_o     (v_wrap),
    .sync_nxt_o (v_sync_nxt),
    .vis_nxt_o  (v_vis_nxt)
  );

  // The vertical counter only steps on a horizontal wrap, so v_wrap already implies h_wrap.
  always_comb begin
    ctl_d             = CTL_RST;
    ctl_d.hs          = h_sync_nxt;
    ctl_d.vs          = v_sync_nxt;
    ctl_d.blank       = h_vis_nxt && v_vis_nxt;
    ctl_d.line_start  = h_wrap;
    ctl_d.frame_start = v_wrap;
    frame_cnt_d       = v_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      ctl_q       <= CTL_RST;
      frame_cnt_q <= '0;
    end else begin
      ctl_q       <= ctl_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  vga_ctl_t ctl_p_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      ctl_p_q <= CTL_RST;
    end else begin
      ctl_p_q <= ctl_q;
    end
  end

  assign ctl_out = ctl_p_q;
`else
  assign ctl_out = ctl_q;
`endif

  assign hs          = ctl_out.hs;
  assign vs          = ctl_out.vs;
  assign blank       = ctl_out.blank;
  assign line_start  = ctl_out.line_start;
  assign frame_start = ctl_out.frame_start;
  assign sync        = 1'b0;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-width lines on a short-frame instance, 8-bit frame wrap on a tiny-raster instance.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       rst_s;
  logic [9:0] DrawX, DrawY, x_s, y_s;
  logic       hs, vs, blank, sync, line_start, frame_start;
  logic       hs_s, vs_s, blank_s, sync_s, ls_s, fs_s;
  logic [7:0] frame_count, fc_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  // Full 800-pixel lines, 12-line frame (sync at lines 8..9) to keep frame checks short.
  vga_timing_gen #(
    .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .sync        (sync),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  // 16x8 raster: 128 clocks per frame.
  vga_timing_gen #(
    .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dut_s (
    .vga_clk     (vga_clk),
    .reset       (rst_s),
    .DrawX       (x_s),
    .DrawY       (y_s),
    .hs          (hs_s),
    .vs          (vs_s),
    .blank       (blank_s),
    .sync        (sync_s),
    .line_start  (ls_s),
    .frame_start (fs_s),
    .frame_count (fc_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  initial begin
    int hs_n, hs_first, bl_n, bl_first, ls_n, ls_x;
    int fs_n, fs_x, fs_y, vs_n, vs_x, vs_y;
    int pulses, prev_fc;
    bit found;

    reset = 1'b1;
    rst_s = 1'b1;
    step(2);
    chk("rst_x",     int'(DrawX),       0);
    chk("rst_y",     int'(DrawY),       0);
    chk("rst_hs",    int'(hs),          1);
    chk("rst_vs",    int'(vs),          1);
    chk("rst_blank", int'(blank),       0);
    chk("rst_ls",    int'(line_start),  0);
    chk("rst_fs",    int'(frame_start), 0);
    chk("rst_fc",    int'(frame_count), 0);
    chk("rst_sync",  int'(sync),        0);

    reset = 1'b0;
    step(1);
    chk("rel_x",     int'(DrawX),       1);
    chk("rel_y",     int'(DrawY),       0);
    chk("rel_blank", int'(blank),       PIPE ? 0 : 1);
    chk("rel_ls",    int'(line_start),  0);
    chk("rel_fs",    int'(frame_start), 0);

    step(799);
    chk("l1_x",  int'(DrawX),       0);
    chk("l1_y",  int'(DrawY),       1);
    chk("l1_ls", int'(line_start),  PIPE ? 0 : 1);
    chk("l1_fs", int'(frame_start), 0);

    // One visible line, starting at (0,1).
    hs_n = 0; hs_first = -1; bl_n = 0; bl_first = -1; ls_n = 0; ls_x = -1;
    for (int i = 0; i < 800; i++) begin
      if (!hs) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(DrawX);
      end
      if (blank) begin
        bl_n++;
        if (bl_first < 0) bl_first = int'(DrawX);
      end
      if (line_start) begin
        ls_n++;
        ls_x = int'(DrawX);
      end
      step(1);
    end
    chk("line_hs_len",    hs_n,     96);
    chk("line_hs_start",  hs_first, 656 + PIPE);
    chk("line_blank_len", bl_n,     640);
    chk("line_blank_x",   bl_first, PIPE);
    chk("line_ls_n",      ls_n,     1);
    chk("line_ls_x",      ls_x,     PIPE);

    // One whole frame, starting at (0,2).
    fs_n = 0; fs_x = -1; fs_y = -1; vs_n = 0; vs_x = -1; vs_y = -1; ls_n = 0;
    for (int i = 0; i < 9600; i++) begin
      if (frame_start) begin
        fs_n++;
        fs_x = int'(DrawX);
        fs_y = int'(DrawY);
      end
      if (!vs) begin
        vs_n++;
        if (vs_x < 0) begin
          vs_x = int'(DrawX);
          vs_y = int'(DrawY);
        end
      end
      if (line_start) ls_n++;
      step(1);
    end
    chk("frm_fs_n",   fs_n,             1);
    chk("frm_fs_x",   fs_x,             PIPE);
    chk("frm_fs_y",   fs_y,             0);
    chk("frm_fc",     int'(frame_count), 1);
    chk("frm_vs_len", vs_n,             1600);
    chk("frm_vs_x",   vs_x,             PIPE);
    chk("frm_vs_y",   vs_y,             8);
    chk("frm_ls_n",   ls_n,             12);

    // Reset from inside both sync pulses.
    found = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (DrawX == 10'd700 && DrawY == 10'd9) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    chk("seek_700_9", int'(found), 1);
    chk("mid_hs", int'(hs), 0);
    chk("mid_vs", int'(vs), 0);
    reset = 1'b1;
    #1;
    chk("abort_x",     int'(DrawX),       0);
    chk("abort_y",     int'(DrawY),       0);
    chk("abort_hs",    int'(hs),          1);
    chk("abort_vs",    int'(vs),          1);
    chk("abort_blank", int'(blank),       0);
    chk("abort_ls",    int'(line_start),  0);
    chk("abort_fs",    int'(frame_start), 0);
    chk("abort_fc",    int'(frame_count), 0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("rerel_x",  int'(DrawX), 1);
    chk("rerel_y",  int'(DrawY), 0);
    chk("rerel_hs", int'(hs),    1);
    chk("rerel_vs", int'(vs),    1);
    pulses = 0;
    for (int i = 0; i < 798; i++) begin
      if (line_start || frame_start) pulses++;
      step(1);
    end
    chk("rerel_pulses", pulses, 0);

    // 256 frames on the tiny raster: frame_count must wrap 255->0 at (0,0).
    rst_s = 1'b0;
    prev_fc = 0;
    fs_n = 0;
    found = 1'b0;
    for (int i = 0; i < 33000; i++) begin
      step(1);
      if (fc_s == 8'd0 && prev_fc == 255) begin
        found = 1'b1;
        break;
      end
      if (fs_s) fs_n++;
      prev_fc = int'(fc_s);
    end
    chk("wrap_seen",  int'(found), 1);
    chk("wrap_fs",    int'(fs_s),  PIPE ? 0 : 1);
    chk("wrap_x",     int'(x_s),   0);
    chk("wrap_y",     int'(y_s),   0);
    chk("wrap_fs_n",  fs_n,        255);
    step(1);
    chk("wrap_fs_next", int'(fs_s), PIPE ? 1 : 0);
    chk("wrap_fc_next", int'(fc_s), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
